// File: rtl/int_queue_scheduler_pkg.sv
// Shared sizing helpers and read-side state encodings for the interrupt queue scheduler.
// Pure compile-time content, no logic.
// Imported by the scheduler top and its round-robin arbiter.
package int_queue_scheduler_pkg;

    // Read-side head-prefetch states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // Ceiling log2, valid for positive values below 2^31
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel id width, never narrower than one bit
    function automatic int idWidth(input int numChannels);
        return (clog2(numChannels) < 1) ? 1 : clog2(numChannels);
    endfunction

    // The FIFO carries three entries of slack above the watermark
    function automatic int fifoDepth(input int watermark);
        return watermark + 3;
    endfunction

endpackage

// File: rtl/int_rr_arbiter.sv
// Round-robin pick: first requesting channel strictly after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with FIFO space.
module int_rr_arbiter
    import int_queue_scheduler_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_ID_WIDTH  = idWidth(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [CH_ID_WIDTH-1:0]  pointer,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic [CH_ID_WIDTH-1:0]  grantId,
    output logic                    anyGrant
);

    // Scan channels pointer+1 .. pointer+NUM_CHANNELS and take the first requester
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grantId  = '0;
        anyGrant = 1'b0;
        for (int offset = 1; offset <= NUM_CHANNELS; offset++) begin
            idx = (int'(pointer) + offset) % NUM_CHANNELS;
            if (!anyGrant && req[idx]) begin
                anyGrant   = 1'b1;
                grant[idx] = 1'b1;
                grantId    = CH_ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/int_queue_scheduler.sv
// Arbitrates channel interrupt events into the interrupt FIFO and prefetches its head to the host.
// Latency: request edge -> FIFO write cycle 1, pop cycle 2, fetch cycle 3, interrupt high cycle 4.
// Backpressure: grants stop once occupancy (incl. in-flight write) reaches FIFO depth; host clear pops.
module int_queue_scheduler
    import int_queue_scheduler_pkg::*;
#(
    parameter  int NUM_CHANNELS    = 4,
    parameter  int STATUS_WIDTH    = 4,
    parameter  int WATERMARK_DEPTH = 2,
    localparam int FIFO_DEPTH      = fifoDepth(WATERMARK_DEPTH),
    localparam int CH_ID_WIDTH     = idWidth(NUM_CHANNELS),
    localparam int FIFO_WIDTH      = CH_ID_WIDTH + STATUS_WIDTH,
    localparam int OCC_WIDTH       = clog2(FIFO_DEPTH + 1)
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic [NUM_CHANNELS-1:0]              chReq,
    input  logic [NUM_CHANNELS*STATUS_WIDTH-1:0] chStatus,
    output logic [NUM_CHANNELS-1:0]              chAck,
    output logic                                 fifoWrEn,
    output logic [FIFO_WIDTH-1:0]                fifoWrData,
    output logic                                 fifoRdEn,
    input  logic [FIFO_WIDTH-1:0]                fifoRdData,
    input  logic                                 fifoEmpty,
    input  logic                                 fifoFull,
    input  logic                                 intClr,
    output logic                                 interrupt,
    output logic [CH_ID_WIDTH-1:0]               intChannel,
    output logic [STATUS_WIDTH-1:0]              intStatus,
    output logic                                 wMarkIrq,
    output logic                                 overflowErr
);

    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] arbGrant;
    logic [CH_ID_WIDTH-1:0]  arbId;
    logic                    arbAny;
    logic [CH_ID_WIDTH-1:0]  rrPtr;
    logic                    grantNow;
    logic [STATUS_WIDTH-1:0] selStatus;
    logic [OCC_WIDTH-1:0]    occ;
    logic [1:0]              state;
    logic [1:0]              stateNext;

    // A request still held during its ack cycle must not win a second time
    assign eligible = chReq & ~chAck;

    int_rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_ID_WIDTH  (CH_ID_WIDTH)
    ) uArbiter (
        .req      (eligible),
        .pointer  (rrPtr),
        .grant    (arbGrant),
        .grantId  (arbId),
        .anyGrant (arbAny)
    );

    // Occupancy is checked before any same-cycle pop so a full FIFO is never overrun
    assign grantNow  = arbAny && (occ < OCC_WIDTH'(FIFO_DEPTH));
    assign selStatus = chStatus[arbId*STATUS_WIDTH +: STATUS_WIDTH];

    // Write side: register the grant into FIFO strobe, data, ack pulse and rotate the pointer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fifoWrEn   <= 1'b0;
            fifoWrData <= '0;
            chAck      <= '0;
            rrPtr      <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
        end else if (grantNow) begin
            fifoWrEn   <= 1'b1;
            fifoWrData <= {arbId, selStatus};
            chAck      <= arbGrant;
            rrPtr      <= arbId;
        end else begin
            fifoWrEn   <= 1'b0;
            chAck      <= '0;
        end
    end

    // Occupancy: entries in the FIFO plus the write being registered this cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ <= '0;
        end else if (grantNow && !fifoRdEn) begin
            occ <= occ + 1'b1;
        end else if (!grantNow && fifoRdEn) begin
            occ <= occ - 1'b1;
        end
    end

    assign wMarkIrq = (occ >= OCC_WIDTH'(WATERMARK_DEPTH));

    // Sticky flag for a write presented to a full FIFO; only reset clears it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflowErr <= 1'b0;
        end else if (fifoWrEn && fifoFull) begin
            overflowErr <= 1'b1;
        end
    end

    // Read side next-state and pop strobe: pop when the head slot is free or being cleared
    always_comb begin
        fifoRdEn  = 1'b0;
        stateNext = state;
        case (state)
            ST_EMPTY: begin
                fifoRdEn = ~fifoEmpty;
                if (!fifoEmpty) begin
                    stateNext = ST_FETCH;
                end
            end
            ST_FETCH: begin
                stateNext = ST_VALID;
            end
            ST_VALID: begin
                if (intClr) begin
                    fifoRdEn  = ~fifoEmpty;
                    stateNext = fifoEmpty ? ST_EMPTY : ST_FETCH;
                end
            end
            default: begin
                stateNext = ST_EMPTY;
            end
        endcase
    end

    // Read side state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Head register: capture the FIFO read data the cycle after the pop
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            intChannel <= '0;
            intStatus  <= '0;
        end else if (state == ST_FETCH) begin
            intChannel <= fifoRdData[FIFO_WIDTH-1:STATUS_WIDTH];
            intStatus  <= fifoRdData[STATUS_WIDTH-1:0];
        end
    end

    assign interrupt = (state == ST_VALID);

endmodule

// File: tb/tb_int_queue_scheduler.sv
// Bench for int_queue_scheduler: directed scenarios plus randomized traffic against a queue-level model.
// Includes a behavioural FIFO (sync write, registered read, depth 5) on the DUT's FIFO port.
// Terminates on its own after a fixed number of cycles.
module tb_int_queue_scheduler;

    logic        clock;
    logic        resetn;
    logic [3:0]  chReq;
    logic [15:0] chStatus;
    logic [3:0]  chAck;
    logic        fifoWrEn;
    logic [5:0]  fifoWrData;
    logic        fifoRdEn;
    logic [5:0]  fifoRdData;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        intClr;
    logic        interrupt;
    logic [1:0]  intChannel;
    logic [3:0]  intStatus;
    logic        wMarkIrq;
    logic        overflowErr;

    int vectors     = 0;
    int miscompares = 0;

    int_queue_scheduler #(
        .NUM_CHANNELS    (4),
        .STATUS_WIDTH    (4),
        .WATERMARK_DEPTH (2)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .chReq       (chReq),
        .chStatus    (chStatus),
        .chAck       (chAck),
        .fifoWrEn    (fifoWrEn),
        .fifoWrData  (fifoWrData),
        .fifoRdEn    (fifoRdEn),
        .fifoRdData  (fifoRdData),
        .fifoEmpty   (fifoEmpty),
        .fifoFull    (fifoFull),
        .intClr      (intClr),
        .interrupt   (interrupt),
        .intChannel  (intChannel),
        .intStatus   (intStatus),
        .wMarkIrq    (wMarkIrq),
        .overflowErr (overflowErr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural interrupt FIFO sharing the scheduler reset
    logic [5:0] fifoQ[$];
    always @(posedge clock or negedge resetn) begin
        logic [5:0] head;
        if (!resetn) begin
            fifoQ.delete();
            fifoRdData <= '0;
            fifoEmpty  <= 1'b1;
            fifoFull   <= 1'b0;
        end else begin
            if (fifoRdEn && fifoQ.size() > 0) begin
                head = fifoQ.pop_front();
                fifoRdData <= head;
            end
            if (fifoWrEn && fifoQ.size() < 5) begin
                fifoQ.push_back(fifoWrData);
            end
            fifoEmpty <= (fifoQ.size() == 0);
            fifoFull  <= (fifoQ.size() == 5);
        end
    end

    // Reference model state: accepted events awaiting host clear, in order
    logic [5:0] expQ[$];
    int         grants;
    int         pops;
    int         lastCh;
    int         waitCnt;
    int         ackCount;
    logic       prevInt;
    logic [5:0] lastWrData;
    logic       sawFull;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        resetn     = 1'b0;
        chReq      = '0;
        chStatus   = '0;
        intClr     = 1'b0;
        expQ.delete();
        grants     = 0;
        pops       = 0;
        lastCh     = 3;
        waitCnt    = 0;
        prevInt    = 1'b0;
        lastWrData = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // One clock: called at a negedge with chReq/chStatus already set; returns at the next negedge
    task automatic stepCycle(input logic clr, input logic [3:0] holdMask);
        logic [3:0] elig;
        logic       expGrant;
        int         expCh;
        int         c;
        logic [5:0] expData;
        logic       popNow;
        logic       clrPop;
        intClr   = clr;
        elig     = chReq & ~chAck;
        expGrant = 1'b0;
        expCh    = 0;
        if ((grants - pops) < 5) begin
            for (int k = 1; k <= 4; k++) begin
                c = (lastCh + k) % 4;
                if (!expGrant && elig[c]) begin
                    expGrant = 1'b1;
                    expCh    = c;
                end
            end
        end
        expData = {expCh[1:0], chStatus[expCh*4 +: 4]};
        #1;
        popNow = fifoRdEn;
        clrPop = clr && interrupt;
        @(posedge clock);
        if (expGrant) begin
            expQ.push_back(expData);
            grants++;
            lastCh     = expCh;
            lastWrData = expData;
        end
        if (popNow) pops++;
        if (clrPop && expQ.size() > 0) void'(expQ.pop_front());
        @(negedge clock);
        checkEq("chAck", 32'(chAck), expGrant ? (32'd1 << expCh) : 32'd0);
        checkEq("fifoWrEn", 32'(fifoWrEn), 32'(expGrant));
        checkEq("fifoWrData", 32'(fifoWrData), 32'(lastWrData));
        checkEq("wMarkIrq", 32'(wMarkIrq), 32'((grants - pops) >= 2));
        checkEq("overflowErr", 32'(overflowErr), 32'd0);
        if (clrPop) checkEq("intLowAfterClr", 32'(interrupt), 32'd0);
        if (interrupt && !prevInt) begin
            checkEq("intSpurious", 32'(interrupt), 32'(expQ.size() > 0));
            if (expQ.size() > 0) checkEq("intHead", 32'({intChannel, intStatus}), 32'(expQ[0]));
        end
        if (!interrupt && expQ.size() > 0) waitCnt++;
        else waitCnt = 0;
        checkEq("intLatency", 32'(waitCnt <= 5), 32'd1);
        prevInt = interrupt;
        if (chAck != 4'b0) ackCount++;
        for (int k = 0; k < 4; k++) begin
            if (chAck[k] && !holdMask[k]) chReq[k] = 1'b0;
        end
        intClr = 1'b0;
    endtask

    // Lone event on channel 2 through an idle system, then clear it
    task automatic singleEvent();
        chReq          = 4'b0100;
        chStatus[11:8] = 4'h5;
        stepCycle(1'b0, 4'b0000);
        checkEq("t1Ack", 32'(chAck), 32'h4);
        checkEq("t1WrData", 32'(fifoWrData), 32'h25);
        stepCycle(1'b0, 4'b0000);
        stepCycle(1'b0, 4'b0000);
        checkEq("t1IntCyc3", 32'(interrupt), 32'd0);
        stepCycle(1'b0, 4'b0000);
        checkEq("t1IntCyc4", 32'(interrupt), 32'd1);
        checkEq("t1Chan", 32'(intChannel), 32'd2);
        checkEq("t1Stat", 32'(intStatus), 32'd5);
        stepCycle(1'b1, 4'b0000);
        checkEq("t1Clr", 32'(interrupt), 32'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        chReq    = '0;
        chStatus = '0;
        intClr   = 1'b0;
        ackCount = 0;
        sawFull  = 1'b0;

        // Reset state
        doReset();
        checkEq("rstOut", 32'({chAck, fifoWrEn, fifoWrData, fifoRdEn, interrupt,
                               intChannel, intStatus, wMarkIrq, overflowErr}), 32'd0);

        // Single event latency and clear
        singleEvent();

        // Fairness: all four request together, then ch0 and ch3 re-raise
        doReset();
        chReq    = 4'b1111;
        chStatus = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b0, 4'b0000);
            checkEq("t2Order", 32'(chAck), 32'd1 << i);
        end
        chReq[0] = 1'b1;
        chReq[3] = 1'b1;
        stepCycle(1'b0, 4'b0000);
        checkEq("t2Reraise0", 32'(chAck), 32'h1);
        stepCycle(1'b0, 4'b0000);
        checkEq("t2Reraise3", 32'(chAck), 32'h8);

        // Fill: ch1 requests continuously with no host clear
        doReset();
        chReq         = 4'b0010;
        chStatus[7:4] = 4'hA;
        ackCount      = 0;
        sawFull       = 1'b0;
        repeat (20) begin
            stepCycle(1'b0, 4'b0010);
            if (fifoFull) sawFull = 1'b1;
        end
        checkEq("t3Acks", 32'(ackCount), 32'd6);
        checkEq("t3FullSeen", 32'(sawFull), 32'd1);
        checkEq("t3WMark", 32'(wMarkIrq), 32'd1);

        // Clear at full occupancy while ch0 requests: grant deferred one cycle
        chReq[0]      = 1'b1;
        chStatus[3:0] = 4'h7;
        stepCycle(1'b1, 4'b0010);
        checkEq("t5NoGrant", 32'(chAck), 32'd0);
        stepCycle(1'b0, 4'b0010);
        checkEq("t5Grant", 32'(chAck), 32'h1);

        // Reset mid-operation with head valid and three entries queued
        doReset();
        chReq    = 4'b1111;
        chStatus = 16'h9876;
        repeat (6) stepCycle(1'b0, 4'b0000);
        checkEq("t6IntUp", 32'(interrupt), 32'd1);
        resetn = 1'b0;
        #1;
        checkEq("t6RstOut", 32'({chAck, fifoWrEn, fifoWrData, fifoRdEn, interrupt,
                                 intChannel, intStatus, wMarkIrq, overflowErr}), 32'd0);
        doReset();
        singleEvent();

        // Randomized traffic: light clearing then heavy clearing
        doReset();
        for (int phase = 0; phase < 2; phase++) begin
            repeat (300) begin
                for (int c = 0; c < 4; c++) begin
                    if (!chReq[c] && $urandom_range(0, 2) == 0) begin
                        chReq[c]          = 1'b1;
                        chStatus[c*4 +: 4] = 4'($urandom);
                    end
                end
                stepCycle($urandom_range(0, 3) < ((phase == 0) ? 1 : 3), 4'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
